mem_req_ctrl: RTL and testbench

- CPU-side front end for the RAM1/UART memory controller.
- Sits between the pipeline MEM stage and the RAM1/UART controller.
- Turns one MEM-stage load or store into exactly one tagged transaction on the controller's mem_act handshake.
- Stalls the pipeline until the controller reports completion, then returns read data and releases the stall for one cycle.

---
 rtl/mem_req_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: turns one MEM-stage load/store into one tagged transaction for the RAM1/UART controller.
// Define UART_STATUS_EN to serve UART_STAT_ADDR locally without a controller transaction.
module mem_req_ctrl #(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 16,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 16'hBF01,
    parameter int                TIMEOUT_CYC    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              done_pulse,
    output logic              err_timeout,
    output logic              need_to_work,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_value,
    output logic [31:0]       mem_act,
    input  logic [31:0]       mem_act_ack,
    input  logic              uart_work_done,
    input  logic [DATA_W-1:0] result,
    input  logic [3:0]        q_front,
    input  logic [3:0]        q_tail,
    input  logic              tbre
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         act_q, act_d;
    logic                ntw_q, ntw_d, rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   value_q, value_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                unused_ok;

    assign unused_ok    = ^{UART_DATA_ADDR, UART_STAT_ADDR, q_front, q_tail, tbre};
    assign stall        = (state_q == IDLE && (req_rd || req_wr)) || state_q == ISSUE || state_q == WAIT;
    assign done_pulse   = state_q == DONE;
    assign err_timeout  = state_q == DONE && err_q;
    assign rdata        = rdata_q;
    assign need_to_work = ntw_q;
    assign mem_rd       = rd_q;
    assign mem_wr       = wr_q;
    assign mem_addr     = addr_q;
    assign mem_value    = value_q;
    assign mem_act      = act_q;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        ntw_d   = ntw_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        value_d = value_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_rd || req_wr) begin
`ifdef UART_STATUS_EN
                if (req_addr == UART_STAT_ADDR) begin
                    state_d = DONE;
                    rdata_d = req_wr ? rdata_q : {{(DATA_W-2){1'b0}}, q_front != q_tail, tbre};
                end else
`endif
                state_d = ISSUE;
            end
            ISSUE: begin
                addr_d  = req_addr;
                value_d = req_wdata;
                wr_d    = req_wr;
                rd_d    = req_rd && !req_wr;
                ntw_d   = 1'b1;
                act_d   = act_q + 32'd1;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = WAIT;
            end
            WAIT: if (uart_work_done && mem_act_ack == act_q) begin
                rdata_d = rd_q ? result : rdata_q;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (TIMEOUT_CYC != 0 && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ntw_d   = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= '0;
            ntw_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            ntw_q   <= ntw_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed and randomized accesses against a transaction-level model of mem_req_ctrl.
module tb_mem_req_ctrl;
    localparam int TO = 16;

    logic        clk = 0, rst = 1;
    logic        req_rd = 0, req_wr = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        stall, done_pulse, err_timeout, need_to_work, mem_rd, mem_wr;
    logic [15:0] rdata, mem_addr, mem_value;
    logic [31:0] mem_act, mem_act_ack = 0;
    logic        uart_work_done = 0;
    logic [15:0] result = 0;
    logic [3:0]  q_front = 0, q_tail = 0;
    logic        tbre = 0;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] tag_m = 0;
    logic [15:0] rd_m = 0;

    mem_req_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .done_pulse(done_pulse),
        .err_timeout(err_timeout), .need_to_work(need_to_work), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_value(mem_value), .mem_act(mem_act), .mem_act_ack(mem_act_ack),
        .uart_work_done(uart_work_done), .result(result), .q_front(q_front), .q_tail(q_tail), .tbre(tbre)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // delay = WAIT cycle index (1-based) on which the controller acks; 0 = never acks
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] res, input int delay, input bit stale);
        bit          bypass, to, got;
        logic [31:0] etag;
        logic [15:0] erd;
        int          ej, j;
        bypass = 0;
`ifdef UART_STATUS_EN
        bypass = (addr == 16'hBF01);
`endif
        to   = !bypass && (delay == 0 || delay > TO);
        etag = bypass ? tag_m : tag_m + 32'd1;
        ej   = bypass ? 1 : to ? TO + 2 : delay + 2;
        erd  = to ? 16'hFFFF : wr ? rd_m : bypass ? {14'b0, q_front != q_tail, tbre} : res;
        got  = 0;
        j    = 0;
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
        #1 chk("stall_on_req", stall, 1);
        while (!got && j < ej + 4) begin
            j++;
            @(negedge clk);
            uart_work_done = stale;
            mem_act_ack    = etag - 32'd1;
            result         = 16'($urandom);
            if (!bypass && delay != 0 && j == delay + 1) begin
                uart_work_done = 1; mem_act_ack = etag; result = res;
            end
            #1;
            if (done_pulse) got = 1;
            else if (j >= 2) begin
                chk("wait_stall", stall, 1);
                chk("wait_act", mem_act, etag);
                chk("wait_ctl", {need_to_work, mem_rd, mem_wr}, {1'b1, rd && !wr, wr});
                chk("wait_addr", mem_addr, addr);
                chk("wait_value", mem_value, wdata);
            end
        end
        chk("done_latency", j, ej);
        chk("done_rdata", rdata, erd);
        chk("done_err", err_timeout, to);
        chk("done_stall", stall, 0);
        rd_m  = erd;
        tag_m = etag;
        @(negedge clk);
        req_rd = 0; req_wr = 0; uart_work_done = 0;
        #1;
        chk("idle_stall", stall, 0);
        chk("idle_done", {done_pulse, err_timeout}, 0);
        chk("idle_ctl", {need_to_work, mem_rd, mem_wr}, 0);
        chk("idle_act", mem_act, tag_m);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_act", mem_act, 0);
        chk("rst_ctl", {need_to_work, mem_rd, mem_wr, done_pulse, err_timeout}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_value", mem_value, 0);
        chk("rst_rdata", rdata, 0);

        access(1, 0, 16'h0010, 16'h0000, 16'h1234, 10, 0);
        access(0, 1, 16'hBF00, 16'h0041, 16'h0000, 6, 1);
        access(1, 0, 16'h0020, 16'h0000, 16'h5555, 0, 0);
        access(1, 0, 16'h0022, 16'h0000, 16'hA5A5, 1, 0);
        access(1, 0, 16'h0024, 16'h0000, 16'h0BEE, TO, 1);
        access(1, 0, 16'h0026, 16'h0000, 16'h0CAF, TO + 1, 0);
        access(1, 1, 16'h0028, 16'h7777, 16'h1111, 3, 0);
        q_front = 3; q_tail = 5; tbre = 1;
        access(1, 0, 16'hBF01, 16'h0000, 16'h2222, 4, 0);
        access(0, 1, 16'hBF01, 16'h00FF, 16'h3333, 2, 0);

        for (int i = 0; i < 10; i++) begin
            int k;
            k = $urandom_range(0, 2);
            q_front = 4'($urandom); q_tail = 4'($urandom); tbre = 1'($urandom);
            access(k != 1, k != 0, ($urandom_range(0, 3) == 0) ? 16'hBF01 : 16'($urandom),
                   16'($urandom), 16'($urandom), $urandom_range(0, 20), 1'($urandom));
        end

        @(negedge clk);
        force dut.act_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.act_q;
        tag_m = 32'hFFFF_FFFF;
        #1 chk("wrap_pre", mem_act, 32'hFFFF_FFFF);
        access(1, 0, 16'h0030, 16'h0000, 16'h4321, 5, 1);
        chk("wrap_zero", mem_act, 0);

        @(negedge clk);
        req_rd = 1; req_addr = 16'h0040;
        repeat (4) @(negedge clk);
        rst = 1; req_rd = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_state", {done_pulse, need_to_work, mem_rd}, 0);
        chk("midrst_act", mem_act, 0);
        @(negedge clk);
        #1 chk("midrst_nodone", done_pulse, 0);
        tag_m = 0; rd_m = 0;
        access(1, 0, 16'h0042, 16'h0000, 16'h9876, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
